x_mux_alct_tx: RTL and testbench

2-to-1 multiplexer/serializer for the ALCT single-cable link, transmit side. It accepts 40 MHz word pairs (1st-in-time, 2nd-in-time) and drives them out at 80 MHz, 1st word first. It sits at the output toward the cable, feeding IOB FFs, and pairs with the 80-to-40 MHz demultiplexer at the far end. A 2-pair buffer absorbs one-cycle strobe jitter; drops and phase slips are flagged.

---
 rtl/x_mux_alct_tx_pkg.sv | 13 +
 rtl/x_mux_alct_tx_if.sv | 26 ++
 rtl/x_mux_alct_tx_pairfifo.sv | 52 +++++
 rtl/x_mux_alct_tx.sv | 140 ++++++++++++++
 tb/tb_x_mux_alct_tx.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/x_mux_alct_tx_pkg.sv
// Shared types and constants for the ALCT transmit-side 2:1 word multiplexer.
package x_mux_alct_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2
    } state_t;

    localparam int PAIR_DEPTH = 2;
    localparam int OCC_W      = 2;

endpackage

// File: rtl/x_mux_alct_tx_if.sv
// Pair input / multiplexed output bundle of the ALCT transmit multiplexer.
interface x_mux_alct_tx_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] din1st;
    logic [WIDTH-1:0] din2nd;
    logic             din_vld;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             dout_1st;
    logic             dout_vld;
    logic             ovf;
    logic             slip;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output din1st, din2nd, din_vld, clr_err,
        input  dout, dout_1st, dout_vld, ovf, slip, drop_cnt
    );

    modport slave (
        input  din1st, din2nd, din_vld, clr_err,
        output dout, dout_1st, dout_vld, ovf, slip, drop_cnt
    );
endinterface

// File: rtl/x_mux_alct_tx_pairfifo.sv
// Two-entry FIFO of {1st,2nd} word pairs; read data is the oldest entry, so a
// same-cycle push into a full FIFO never shows through to the pop.
module x_mux_alct_pairfifo
    import x_mux_alct_tx_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clock_2x,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr1st,
    input  logic [WIDTH-1:0] wr2nd,
    output logic [WIDTH-1:0] rd1st,
    output logic [WIDTH-1:0] rd2nd,
    output logic [OCC_W-1:0] count
);
    logic [WIDTH-1:0] mem1st [PAIR_DEPTH];
    logic [WIDTH-1:0] mem2nd [PAIR_DEPTH];
    logic             wptr;
    logic             rptr;

    always_ff @(posedge clock_2x or posedge reset) begin
        if (reset) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= '0;
            for (int i = 0; i < PAIR_DEPTH; i++) begin
                mem1st[i] <= '0;
                mem2nd[i] <= '0;
            end
        end else begin
            if (push) begin
                mem1st[wptr] <= wr1st;
                mem2nd[wptr] <= wr2nd;
                wptr         <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd1st = mem1st[rptr];
    assign rd2nd = mem2nd[rptr];

endmodule

// File: rtl/x_mux_alct_tx.sv
// ALCT single-cable transmit side: 40 MHz word pairs out at 80 MHz, 1st word
// first, through a 2-pair jitter buffer with drop and phase-slip flags.
//
//   state | meaning
//   IDLE  | no pair in flight; pops a waiting pair (dout still idle)
//   S1    | drives the 1st word of the popped pair
//   S2    | drives the 2nd word; pre-pops the next pair if one waits
module x_mux_alct_tx
    import x_mux_alct_tx_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0,
    parameter int               CNT_W     = 8
) (
    input  logic           clock_2x,
    input  logic           reset,
    x_mux_alct_tx_if.slave bus
);
    state_t           state;
    state_t           state_nxt;
    logic             pop;
    logic             push;
    logic             drop;
    logic             slip_evt;
    logic [OCC_W-1:0] count;
    logic [WIDTH-1:0] rd1st;
    logic [WIDTH-1:0] rd2nd;
    logic [WIDTH-1:0] hold_1st;
    logic [WIDTH-1:0] hold_2nd;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_nxt;
    logic             dout_1st_q;
    logic             dout_1st_nxt;
    logic             dout_vld_q;
    logic             dout_vld_nxt;
    logic             ovf_q;
    logic             slip_q;
    logic [CNT_W-1:0] drop_cnt_q;

    // A pair may enter a full buffer only when a pop frees the oldest slot.
    assign push     = bus.din_vld && ((count < OCC_W'(PAIR_DEPTH)) || pop);
    assign drop     = bus.din_vld && !push;
    assign slip_evt = (state == S2) && (state_nxt == IDLE) && bus.din_vld;

    x_mux_alct_pairfifo #(.WIDTH(WIDTH)) u_pairfifo (
        .clock_2x (clock_2x),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .wr1st    (bus.din1st),
        .wr2nd    (bus.din2nd),
        .rd1st    (rd1st),
        .rd2nd    (rd2nd),
        .count    (count)
    );

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        dout_nxt     = IDLE_WORD;
        dout_1st_nxt = 1'b0;
        dout_vld_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S1;
                end
            end
            S1: begin
                dout_nxt     = hold_1st;
                dout_1st_nxt = 1'b1;
                dout_vld_nxt = 1'b1;
                state_nxt    = S2;
            end
            S2: begin
                dout_nxt     = hold_2nd;
                dout_vld_nxt = 1'b1;
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_2x or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_1st   <= '0;
            hold_2nd   <= '0;
            dout_q     <= IDLE_WORD;
            dout_1st_q <= 1'b0;
            dout_vld_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            dout_q     <= dout_nxt;
            dout_1st_q <= dout_1st_nxt;
            dout_vld_q <= dout_vld_nxt;
            if (pop) begin
                hold_1st <= rd1st;
                hold_2nd <= rd2nd;
            end
        end
    end

    // clr_err beats a same-cycle drop or slip; that event is not recorded.
    always_ff @(posedge clock_2x or posedge reset) begin
        if (reset) begin
            ovf_q      <= 1'b0;
            slip_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else if (bus.clr_err) begin
            ovf_q      <= 1'b0;
            slip_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != {CNT_W{1'b1}}) begin
                    drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end
            if (slip_evt) begin
                slip_q <= 1'b1;
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_1st = dout_1st_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.ovf      = ovf_q;
    assign bus.slip     = slip_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_x_mux_alct_tx.sv
// Directed bench for the ALCT transmit multiplexer, WIDTH=8, hand-derived vectors.
module tb_x_mux_alct_tx;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic clock_2x = 1'b0;
    logic reset    = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   k;

    // burst of 6 strobes from idle: pair 5 (45/85) is the one dropped
    logic [7:0]  exp4 [13] = '{8'h00, 8'h00, 8'h41, 8'h81, 8'h42, 8'h82, 8'h43,
                               8'h83, 8'h44, 8'h84, 8'h46, 8'h86, 8'h00};
    logic [12:0] first4    = 13'b0010101010100;
    // stream with the 4th strobe one cycle late: idle slot at t=8
    logic [7:0]  exp5 [16] = '{8'h00, 8'h00, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3,
                               8'h00, 8'hA4, 8'hB4, 8'hA5, 8'hB5, 8'hA6, 8'hB6, 8'h00};
    logic [15:0] first5    = 16'b0010101001010100;
    logic [15:0] vld5      = 16'b0000101010010101;

    x_mux_alct_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    x_mux_alct_tx #(
        .WIDTH     (WIDTH),
        .IDLE_WORD (8'h00),
        .CNT_W     (CNT_W)
    ) dut (
        .clock_2x (clock_2x),
        .reset    (reset),
        .bus      (bus.slave)
    );

    always #5 clock_2x = ~clock_2x;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic vld, input logic [7:0] a, input logic [7:0] b, input logic clr);
        bus.din_vld = vld;
        bus.din1st  = a;
        bus.din2nd  = b;
        bus.clr_err = clr;
        @(posedge clock_2x);
        #2;
    endtask

    initial begin
        bus.din_vld = 1'b0;
        bus.din1st  = 8'h00;
        bus.din2nd  = 8'h00;
        bus.clr_err = 1'b0;

        #1 reset = 1'b1;
        #1;
        check("rst_dout", 32'(bus.dout), 32'h0);
        check("rst_1st", 32'(bus.dout_1st), 32'h0);
        check("rst_vld", 32'(bus.dout_vld), 32'h0);
        check("rst_ovf", 32'(bus.ovf), 32'h0);
        check("rst_slip", 32'(bus.slip), 32'h0);
        check("rst_drop", 32'(bus.drop_cnt), 32'h0);
        @(posedge clock_2x);
        @(posedge clock_2x);
        #2 reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 8'h00, 1'b0);
            check("idle_dout", 32'(bus.dout), 32'h0);
            check("idle_vld", 32'(bus.dout_vld), 32'h0);
        end
        check("idle_ovf", 32'(bus.ovf), 32'h0);
        check("idle_slip", 32'(bus.slip), 32'h0);

        // single pair: 1st word two edges after the sampling edge
        cyc(1'b1, 8'hA1, 8'hB2, 1'b0);
        check("single_t0_vld", 32'(bus.dout_vld), 32'h0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        check("single_t1_vld", 32'(bus.dout_vld), 32'h0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        check("single_t2_dout", 32'(bus.dout), 32'hA1);
        check("single_t2_1st", 32'(bus.dout_1st), 32'h1);
        check("single_t2_vld", 32'(bus.dout_vld), 32'h1);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        check("single_t3_dout", 32'(bus.dout), 32'hB2);
        check("single_t3_1st", 32'(bus.dout_1st), 32'h0);
        check("single_t3_vld", 32'(bus.dout_vld), 32'h1);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        check("single_t4_dout", 32'(bus.dout), 32'h0);
        check("single_t4_vld", 32'(bus.dout_vld), 32'h0);

        // 16 pairs every 2nd cycle: dout at edge t is t-1
        for (int t = 0; t < 34; t++) begin
            cyc((t % 2 == 0) && (t < 32), 8'(t + 1), 8'(t + 2), 1'b0);
            if (t >= 2) begin
                check("stream_dout", 32'(bus.dout), 32'(t - 1));
                check("stream_1st", 32'(bus.dout_1st), 32'(t % 2 == 0));
                check("stream_vld", 32'(bus.dout_vld), 32'h1);
            end
        end
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        check("stream_end_vld", 32'(bus.dout_vld), 32'h0);
        check("stream_ovf", 32'(bus.ovf), 32'h0);
        check("stream_slip", 32'(bus.slip), 32'h0);

        // strobe every cycle for 6 cycles
        k = 0;
        for (int t = 0; t < 13; t++) begin
            if (t < 6) begin
                k++;
                cyc(1'b1, 8'(32'h40 + k), 8'(32'h80 + k), 1'b0);
            end else begin
                cyc(1'b0, 8'h00, 8'h00, 1'b0);
            end
            check("burst_dout", 32'(bus.dout), 32'(exp4[t]));
            check("burst_1st", 32'(bus.dout_1st), 32'(first4[t]));
            check("burst_vld", 32'(bus.dout_vld), 32'(exp4[t] != 8'h00));
            if (t == 3) check("burst_ovf_before", 32'(bus.ovf), 32'h0);
            if (t == 4) check("burst_ovf_set", 32'(bus.ovf), 32'h1);
        end
        check("burst_drop_cnt", 32'(bus.drop_cnt), 32'h1);
        check("burst_slip", 32'(bus.slip), 32'h0);

        // stream with one late strobe
        k = 0;
        for (int t = 0; t < 16; t++) begin
            if (vld5[t]) begin
                k++;
                cyc(1'b1, 8'(32'hA0 + k), 8'(32'hB0 + k), 1'b0);
            end else begin
                cyc(1'b0, 8'h00, 8'h00, 1'b0);
            end
            check("slip_dout", 32'(bus.dout), 32'(exp5[t]));
            check("slip_1st", 32'(bus.dout_1st), 32'(first5[t]));
            check("slip_vld", 32'(bus.dout_vld), 32'(exp5[t] != 8'h00));
            if (t == 6) check("slip_before", 32'(bus.slip), 32'h0);
            if (t == 7) check("slip_set", 32'(bus.slip), 32'h1);
        end
        check("slip_ovf_kept", 32'(bus.ovf), 32'h1);
        check("slip_drop_kept", 32'(bus.drop_cnt), 32'h1);
        cyc(1'b0, 8'h00, 8'h00, 1'b1);
        check("clr_slip", 32'(bus.slip), 32'h0);
        check("clr_ovf", 32'(bus.ovf), 32'h0);
        check("clr_drop", 32'(bus.drop_cnt), 32'h0);

        // clr_err coinciding with the only drop of a burst: drop not recorded
        for (int t = 0; t < 13; t++) begin
            cyc(t < 6, 8'(32'h60 + t), 8'(32'h70 + t), t == 4);
            if (t == 10) check("clrprio_dout", 32'(bus.dout), 32'h65);
        end
        check("clrprio_ovf", 32'(bus.ovf), 32'h0);
        check("clrprio_drop", 32'(bus.drop_cnt), 32'h0);

        // long continuous strobing saturates the drop counter
        for (int i = 0; i < 600; i++) cyc(1'b1, 8'h11, 8'h22, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0);
        check("sat_drop", 32'(bus.drop_cnt), 32'hFF);
        check("sat_ovf", 32'(bus.ovf), 32'h1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'h33, 8'h44, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0);
        check("sat_hold", 32'(bus.drop_cnt), 32'hFF);
        cyc(1'b0, 8'h00, 8'h00, 1'b1);
        check("sat_clr", 32'(bus.drop_cnt), 32'h0);

        // reset while dout holds a 1st word
        cyc(1'b1, 8'h5A, 8'hC3, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        check("midrst_pre_dout", 32'(bus.dout), 32'h5A);
        check("midrst_pre_1st", 32'(bus.dout_1st), 32'h1);
        reset = 1'b1;
        #1;
        check("midrst_dout", 32'(bus.dout), 32'h0);
        check("midrst_1st", 32'(bus.dout_1st), 32'h0);
        check("midrst_vld", 32'(bus.dout_vld), 32'h0);
        @(posedge clock_2x);
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 8'h00, 8'h00, 1'b0);
            check("postrst_dout", 32'(bus.dout), 32'h0);
            check("postrst_vld", 32'(bus.dout_vld), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
